// File: rtl/add_pipe_c.sv
// Pipelined adder/subtractor: the word is cut into equal segments, one segment is added per stage
// with a prefix-carry adder, and valid/ready backpressure stalls the whole pipe at once.
package lau_pkg;
    typedef enum logic {SLOW, FAST} speed_e;
endpackage

module add_pipe_c #(
    parameter int             width  = 8,
    parameter int             stages = 2,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             CI,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [width-1:0] S,
    output logic             CO,
    output logic             V
);
    localparam int SW = width / stages;

    if ((stages < 1) || (stages > width) || ((width % stages) != 0)) begin : g_bad_params
        $error("add_pipe_c: stages must lie in 1..width and divide width");
    end

    // Segment adder returning {carry_out, sum}; FAST is Kogge-Stone, SLOW is a serial prefix chain.
    function automatic logic [SW:0] padd(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                         input logic cin);
        logic [SW-1:0] g, p, gg, pp, gt, pt, c;
        g     = x & y;
        p     = x ^ y;
        gg    = g;
        pp    = p;
        gg[0] = g[0] | (p[0] & cin);
        if (speed == lau_pkg::FAST) begin
            for (int d = 1; d < SW; d = d * 2) begin
                gt = gg;
                pt = pp;
                for (int i = d; i < SW; i++) begin
                    gg[i] = gt[i] | (pt[i] & gt[i-d]);
                    pp[i] = pt[i] & pt[i-d];
                end
            end
        end else begin
            for (int i = 1; i < SW; i++) begin
                gg[i] = g[i] | (p[i] & gg[i-1]);
            end
        end
        c[0] = cin;
        for (int i = 1; i < SW; i++) begin
            c[i] = gg[i-1];
        end
        return {gg[SW-1], p ^ c};
    endfunction

    logic adv;

    assign adv        = ~out_valid_o | out_ready_i;
    assign in_ready_o = adv;

    for (genvar k = 0; k < stages; k++) begin : stg
        // Stage k sees only the operand bits not yet consumed, re-based so its segment sits at bit 0.
        localparam int IW = width - k * SW;

        logic [IW-1:0]         a_in, b_in;
        logic                  c_in, v_in;
        logic [SW:0]           res;
        logic [(k+1)*SW-1:0]   s_nxt;
        logic [(k+1)*SW-1:0]   s_q;
        logic                  c_q, valid_q;

        if (k == 0) begin : g_src
            assign a_in  = A;
            assign b_in  = sub_i ? ~B : B;
            assign c_in  = CI;
            assign v_in  = in_valid_i;
            assign s_nxt = res[SW-1:0];
        end else begin : g_src
            assign a_in  = stg[k-1].g_ops.a_q;
            assign b_in  = stg[k-1].g_ops.b_q;
            assign c_in  = stg[k-1].c_q;
            assign v_in  = stg[k-1].valid_q;
            assign s_nxt = {res[SW-1:0], stg[k-1].s_q};
        end

        assign res = padd(a_in[SW-1:0], b_in[SW-1:0], c_in);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
                c_q     <= 1'b0;
                s_q     <= '0;
            end else if (adv) begin
                valid_q <= v_in;
                c_q     <= res[SW];
                s_q     <= s_nxt;
            end
        end

        if (IW > SW) begin : g_ops
            logic [IW-SW-1:0] a_q, b_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[IW-1:SW];
                    b_q <= b_in[IW-1:SW];
                end
            end
        end

        if (k == stages - 1) begin : g_last
            logic ov_q;

            // Carry into the MSB is recovered from the MSB's own operand and sum bits.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    ov_q <= 1'b0;
                end else if (adv) begin
                    ov_q <= a_in[SW-1] ^ b_in[SW-1] ^ res[SW-1] ^ res[SW];
                end
            end
        end
    end

    assign out_valid_o = stg[stages-1].valid_q;
    assign S           = stg[stages-1].s_q;
    assign CO          = stg[stages-1].c_q;
    assign V           = stg[stages-1].g_last.ov_q;

endmodule

// File: tb/tb_add_pipe_c.sv
// Directed bench for add_pipe_c: an 8-bit/2-stage instance with hand-computed vectors and a
// 16-bit/4-stage instance streamed against an arithmetic model under random stalls.
module tb_add_pipe_c;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic       in_valid, in_ready, out_valid, out_ready, ci, sub, co, v;
    logic [7:0] a, b, s;

    add_pipe_c #(.width(8), .stages(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .A(a), .B(b), .CI(ci), .sub_i(sub),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .S(s), .CO(co), .V(v)
    );

    logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, ci_w, sub_w, co_w, v_w;
    logic [15:0] a_w, b_w, s_w;

    add_pipe_c #(.width(16), .stages(4)) dut_w (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid_w), .in_ready_o(in_ready_w),
        .A(a_w), .B(b_w), .CI(ci_w), .sub_i(sub_w),
        .out_valid_o(out_valid_w), .out_ready_i(out_ready_w),
        .S(s_w), .CO(co_w), .V(v_w)
    );

    int total  = 0;
    int passed = 0;

    logic [17:0] exp_q[$];

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("[TB] FAIL %s: got %0h, want %0h", tag, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic vld, input logic [7:0] aa, input logic [7:0] bb,
                                  input logic c, input logic sb);
        in_valid = vld;
        a        = aa;
        b        = bb;
        ci       = c;
        sub      = sb;
    endtask

    // Output word of the narrow instance checked as {valid, CO, V, S}.
    task automatic check_result(input string tag, input logic [7:0] es, input logic ec,
                                input logic ev);
        check_output(tag, {out_valid, co, v, s}, {1'b1, ec, ev, es});
    endtask

    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y,
                                            input logic c, input logic sb);
        logic [15:0] yy;
        logic [16:0] r;
        yy = sb ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {16'b0, c};
        return {r[16], (x[15] == yy[15]) && (r[15] != x[15]), r[15:0]};
    endfunction

    // Sample the wide instance just before the coming edge and score both transfers.
    task automatic score_wide(input string tag);
        logic [17:0] want;
        #1;
        if (out_valid_w && out_ready_w) begin
            if (exp_q.size() == 0) begin
                check_output({tag, "_spurious"}, {31'b0, out_valid_w}, 32'd0);
            end else begin
                want = exp_q.pop_front();
                check_output(tag, {14'b0, co_w, v_w, s_w}, {14'b0, want});
            end
        end
        if (in_valid_w && in_ready_w) exp_q.push_back(model16(a_w, b_w, ci_w, sub_w));
        @(posedge clk);
        #1;
    endtask

    logic [15:0] dir_a[4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] dir_b[4] = '{16'h0001, 16'h0001, 16'h0007, 16'h8000};
    logic        dir_c[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        dir_s[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n       = 1'b0;
        out_ready   = 1'b1;
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        in_valid_w  = 1'b0;
        out_ready_w = 1'b1;
        a_w = '0; b_w = '0; ci_w = 1'b0; sub_w = 1'b0;

        tick();
        tick();
        check_output("reset_state", {in_ready, out_valid, co, v, s}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        check_output("reset_wide", {30'b0, in_ready_w, out_valid_w}, {30'b0, 1'b1, 1'b0});
        rst_n = 1'b1;
        tick();

        // Carry ripples across the segment boundary: FF + 01.
        apply_stimulus(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check_output("latency_early", {31'b0, out_valid}, 32'd0);
        tick();
        check_result("ff_plus_01", 8'h00, 1'b1, 1'b0);
        tick();

        // Subtract with carry-in, then positive overflow, back to back.
        apply_stimulus(1'b1, 8'h05, 8'h07, 1'b1, 1'b1);
        tick();
        apply_stimulus(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check_result("sub_05_07", 8'hFE, 1'b0, 1'b0);
        tick();
        check_result("ovf_7f_01", 8'h80, 1'b0, 1'b1);
        tick();
        check_output("bubble_after", {31'b0, out_valid}, 32'd0);

        // Three consecutive transfers stream out on consecutive cycles.
        apply_stimulus(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, 8'h0F, 8'hF1, 1'b0, 1'b0);
        tick();
        check_result("stream_1", 8'h30, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h80, 8'h80, 1'b0, 1'b0);
        tick();
        check_result("stream_2", 8'h00, 1'b1, 1'b0);
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        check_result("stream_3", 8'h00, 1'b1, 1'b1);
        tick();
        check_output("stream_empty", {31'b0, out_valid}, 32'd0);

        // Fill the pipe with the consumer stalled, hold, then drain in order.
        out_ready = 1'b0;
        apply_stimulus(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, 8'h40, 8'h40, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
        #1;
        check_output("stall_ready", {31'b0, in_ready}, 32'd0);
        check_result("stall_head", 8'h03, 1'b0, 1'b0);
        tick();
        check_result("stall_hold1", 8'h03, 1'b0, 1'b0);
        tick();
        check_result("stall_hold2", 8'h03, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        check_output("unstall_ready", {31'b0, in_ready}, 32'd1);
        tick();
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check_result("drain_2", 8'h80, 1'b0, 1'b1);
        tick();
        check_result("drain_3", 8'hFF, 1'b1, 1'b0);
        tick();
        check_output("drain_empty", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset with two transfers in flight discards them.
        apply_stimulus(1'b1, 8'h11, 8'h11, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, 8'h22, 8'h22, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_output("async_clear", {out_valid, co, v, s}, {1'b0, 1'b0, 1'b0, 8'h00});
        check_output("ready_in_reset", {31'b0, in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            check_output("post_reset_quiet", {31'b0, out_valid}, 32'd0);
        end
        apply_stimulus(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        check_result("post_reset_new", 8'h46, 1'b0, 1'b0);

        // Wide instance: directed vectors first, then random traffic and stalls.
        for (int n = 0; n < 300; n++) begin
            if (n < 4) begin
                in_valid_w  = 1'b1;
                out_ready_w = 1'b1;
                a_w = dir_a[n]; b_w = dir_b[n]; ci_w = dir_c[n]; sub_w = dir_s[n];
            end else begin
                in_valid_w  = ($urandom_range(0, 3) != 0);
                out_ready_w = ($urandom_range(0, 3) != 0);
                a_w   = 16'($urandom);
                b_w   = 16'($urandom);
                ci_w  = 1'($urandom_range(0, 1));
                sub_w = 1'($urandom_range(0, 1));
            end
            score_wide("wide_result");
        end
        in_valid_w  = 1'b0;
        out_ready_w = 1'b1;
        for (int n = 0; n < 12 && exp_q.size() > 0; n++) begin
            score_wide("wide_drain");
        end
        check_output("wide_leftover", exp_q.size(), 32'd0);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
